// File: rtl/trans_pkg.sv
// Shared constants and helper functions for the keep-packing stream datapath.
package trans_pkg;

  localparam int unsigned ByteW = 8;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Number of set bits; wide enough for the largest keep vector (64 bytes).
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/keep_compact.sv
// Combinational byte compactor: moves kept bytes down to byte 0 in ascending order.
module keep_compact
  import trans_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic [N*ByteW-1:0] tdata,
  input  logic [N-1:0]       tkeep,
  output logic [N*ByteW-1:0] packed_data,
  output logic [CW-1:0]      pop
);

  // Bytes above the popcount stay zero so the caller can OR the result into a buffer.
  always_comb begin
    int unsigned idx;
    idx = 0;
    packed_data = '0;
    for (int i = 0; i < N; i++) begin
      if (tkeep[i]) begin
        packed_data[idx*ByteW +: ByteW] = tdata[i*ByteW +: ByteW];
        idx++;
      end
    end
  end

  assign pop = CW'(popcount(64'(tkeep)));

endmodule

// File: rtl/trans_keep_pack.sv
// AXI-stream keep packer: compacts sparse beats into dense output beats, one frame at a time.
module trans_keep_pack
  import trans_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 64
) (
  input  logic                            core_clk,
  input  logic                            core_rst,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   in_tdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] in_tkeep,
  input  logic                            in_tvalid,
  output logic                            in_tready,
  input  logic                            in_tlast,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   out_tdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] out_keep,
  output logic                            out_tvalid,
  output logic                            out_tlast,
  input  logic                            out_tready
);

  localparam int unsigned W    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned N    = W / ByteW;
  localparam int unsigned BW   = 2 * W;
  localparam int unsigned CW   = clog2(2 * N);
  localparam logic [CW-1:0] NCnt = CW'(N);

  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lp_q, lp_d;

  logic [W-1:0]  packed_data;
  logic [CW-1:0] pop;
  logic [CW-1:0] new_cnt;
  logic          out_fire, in_fire;

  keep_compact #(
    .N  (N),
    .CW (CW)
  ) u_compact (
    .tdata       (in_tdata),
    .tkeep       (in_tkeep),
    .packed_data (packed_data),
    .pop         (pop)
  );

  // Buffer bytes at index >= cnt are always zero, so the low half is already a valid beat.
  assign out_tdata  = buf_q[W-1:0];
  assign out_tvalid = (cnt_q >= NCnt) || (lp_q && (cnt_q != '0));
  assign out_tlast  = lp_q && (cnt_q <= NCnt);
  assign in_tready  = !lp_q && ((cnt_q < NCnt) || out_tready);

  always_comb begin
    out_keep = '0;
    for (int i = 0; i < N; i++) begin
      out_keep[i] = cnt_q > CW'(i);
    end
  end

  assign out_fire = out_tvalid && out_tready;
  assign in_fire  = in_tvalid && in_tready;

  // Drain first, then append at the post-drain count.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    lp_d    = lp_q;
    new_cnt = '0;
    if (out_fire) begin
      buf_d = {{W{1'b0}}, buf_q[BW-1:W]};
      cnt_d = (cnt_q >= NCnt) ? (cnt_q - NCnt) : '0;
      if (out_tlast) lp_d = 1'b0;
    end
    if (in_fire && ((in_tkeep != '0) || in_tlast)) begin
      new_cnt = cnt_d + pop;
      buf_d   = buf_d | ({{W{1'b0}}, packed_data} << (32'(cnt_d) * ByteW));
      cnt_d   = new_cnt;
      if (in_tlast) lp_d = (new_cnt != '0);
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      lp_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      lp_q  <= lp_d;
    end
  end

endmodule

// File: tb/tb_trans_keep_pack.sv
// Self-checking bench for trans_keep_pack (N = 8) using a byte-queue reference model.
module tb_trans_keep_pack;

  localparam int N = 8;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tlast = 1'b0;
  logic [63:0] out_tdata;
  logic [7:0]  out_keep;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready = 1'b1;

  trans_keep_pack #(
    .C_S_AXI_DATA_WIDTH (64)
  ) dut (
    .core_clk   (core_clk),
    .core_rst   (core_rst),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_keep   (out_keep),
    .out_tvalid (out_tvalid),
    .out_tlast  (out_tlast),
    .out_tready (out_tready)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    int          c;
  } beat_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [7:0]  mq[$];
  logic        lp_m = 1'b0;
  beat_t       obs_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: frame bytes live in a queue; outputs follow from its length and lp.
  always @(negedge core_clk) begin : cmp
    int          sz, take;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        ev, el, er;
    if (core_rst) begin
      mq.delete();
      lp_m = 1'b0;
    end
    sz   = mq.size();
    take = (sz < N) ? sz : N;
    ed   = '0;
    for (int i = 0; i < take; i++) ed[8*i +: 8] = mq[i];
    ek = 8'((16'(1) << take) - 16'(1));
    ev = (sz >= N) || (lp_m && sz > 0);
    el = lp_m && (sz <= N);
    er = !lp_m && ((sz < N) || out_tready);
    check("in_tready", in_tready, er);
    check("out_tvalid", out_tvalid, ev);
    if (ev) begin
      check("out_tdata", out_tdata, ed);
      check("out_keep", out_keep, ek);
      check("out_tlast", out_tlast, el);
    end else if (core_rst) begin
      check("rst_tdata", out_tdata, 0);
      check("rst_keep", out_keep, 0);
      check("rst_tlast", out_tlast, 0);
    end
    if (!core_rst) begin
      if (ev && out_tready) begin
        obs_q.push_back('{d: out_tdata, k: out_keep, l: out_tlast, c: cyc});
        for (int i = 0; i < take; i++) void'(mq.pop_front());
        if (el) lp_m = 1'b0;
      end
      if (in_tvalid && er) begin
        for (int i = 0; i < N; i++) if (in_tkeep[i]) mq.push_back(in_tdata[8*i +: 8]);
        if (in_tlast && mq.size() > 0) lp_m = 1'b1;
      end
    end
    cyc++;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int   t;
    logic acc;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    in_tvalid = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 50) begin
      @(negedge core_clk);
      acc = in_tready;
      @(posedge core_clk);
      #1;
      t++;
    end
    in_tvalid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((mq.size() != 0 || lp_m) && t < 100) begin
      @(posedge core_clk);
      #1;
      t++;
    end
    if (t >= 100) check("drain_timeout", 0, 1);
    repeat (2) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  initial begin : stim
    logic [63:0] held;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] held;
    // Reset state
    @(negedge core_clk);
    check("reset_valid", out_tvalid, 0);
    check("reset_keep", out_keep, 0);
    check("reset_tdata", out_tdata, 0);
    check("reset_ready", in_tready, 1);
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;

    // Dense stream
    obs_q.delete();
    out_tready = 1'b1;
    send(64'h0706050403020100, 8'hFF, 1'b0);
    send(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0);
    send(64'h1716151413121110, 8'hFF, 1'b1);
    drain();
    check("dense_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("dense_d0", obs_q[0].d, 64'h0706050403020100);
      check("dense_d2", obs_q[2].d, 64'h1716151413121110);
      check("dense_k1", obs_q[1].k, 8'hFF);
      check("dense_l1", obs_q[1].l, 0);
      check("dense_l2", obs_q[2].l, 1);
      check("dense_consec", obs_q[2].c - obs_q[0].c, 2);
    end

    // Sparse
    obs_q.delete();
    send(64'h0706050403020100, 8'h55, 1'b0);
    send(64'h1716151413121110, 8'hF0, 1'b1);
    drain();
    check("sparse_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("sparse_d", obs_q[0].d, 64'h1716151406040200);
      check("sparse_k", obs_q[0].k, 8'hFF);
      check("sparse_l", obs_q[0].l, 1);
    end

    // Residual
    obs_q.delete();
    send(64'hA7A6A5A4A3A2A1A0, 8'h3F, 1'b0);
    send(64'hB7B6B5B4B3B2B1B0, 8'h3F, 1'b1);
    drain();
    check("resid_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("resid_d0", obs_q[0].d, 64'hB1B0A5A4A3A2A1A0);
      check("resid_k0", obs_q[0].k, 8'hFF);
      check("resid_l0", obs_q[0].l, 0);
      check("resid_d1", obs_q[1].d, 64'h00000000B5B4B3B2);
      check("resid_k1", obs_q[1].k, 8'h0F);
      check("resid_l1", obs_q[1].l, 1);
    end

    // Backpressure with 10 bytes buffered
    obs_q.delete();
    out_tready = 1'b0;
    send(64'hC7C6C5C4C3C2C1C0, 8'h3F, 1'b0);
    send(64'hD7D6D5D4D3D2D1D0, 8'h0F, 1'b0);
    in_tdata  = 64'hE7E6E5E4E3E2E1E0;
    in_tkeep  = 8'hFF;
    in_tlast  = 1'b1;
    in_tvalid = 1'b1;
    @(negedge core_clk);
    held = out_tdata;
    check("bp_first", held, 64'hD1D0C5C4C3C2C1C0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge core_clk);
      check("bp_ready_low", in_tready, 0);
      check("bp_valid_held", out_tvalid, 1);
      check("bp_data_held", out_tdata, held);
      @(posedge core_clk);
      #1;
    end
    out_tready = 1'b1;
    send(64'hE7E6E5E4E3E2E1E0, 8'hFF, 1'b1);
    drain();
    check("bp_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("bp_d0", obs_q[0].d, 64'hD1D0C5C4C3C2C1C0);
      check("bp_d1", obs_q[1].d, 64'hE5E4E3E2E1E0D3D2);
      check("bp_d2", obs_q[2].d, 64'h000000000000E7E6);
      check("bp_k2", obs_q[2].k, 8'h03);
      check("bp_l2", obs_q[2].l, 1);
    end

    // Degenerate keep = 0
    obs_q.delete();
    send(64'h1122334455667788, 8'h00, 1'b1);
    drain();
    check("degen_last_none", obs_q.size(), 0);
    send(64'h1122334455667788, 8'h00, 1'b0);
    send(64'hFFFFFFFFAAAAAAAA, 8'h0F, 1'b1);
    drain();
    check("degen_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("degen_d", obs_q[0].d, 64'h00000000AAAAAAAA);
      check("degen_k", obs_q[0].k, 8'h0F);
    end

    // Reset mid-frame with cnt = 5 and lp = 1
    obs_q.delete();
    out_tready = 1'b0;
    send(64'h0000005453525150, 8'h1F, 1'b1);
    core_rst = 1'b1;
    @(negedge core_clk);
    check("rst_mid_valid", out_tvalid, 0);
    check("rst_mid_ready", in_tready, 1);
    @(posedge core_clk);
    #1;
    core_rst   = 1'b0;
    out_tready = 1'b1;
    check("rst_mid_none", obs_q.size(), 0);
    send(64'h6766656463626160, 8'hFF, 1'b1);
    drain();
    check("rst_new_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      check("rst_new_d", obs_q[0].d, 64'h6766656463626160);
      check("rst_new_l", obs_q[0].l, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
